// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one 8-bit FIFO write port among NUM_REQ requesters.
// A grant holds until the last beat, MAX_BURST beats, or STALL_LIMIT idle cycles.
module fifo_wr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 8,
  parameter int STALL_LIMIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [7:0]             fifo_din,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   burst_abort
);

  localparam int DATA_W = 8;
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [IW-1:0]      last_gnt, last_gnt_n;
  logic [7:0]         beat_cnt, beat_cnt_n;
  logic [7:0]         stall_cnt, stall_cnt_n;

  logic          cur_valid, cur_last, accept;
  logic          hit_last, hit_max, hit_stall, end_burst;
  logic          win_found;
  logic [IW-1:0] win_idx;

  // Scanning from after+1 with wrap visits the previous owner last, so it only
  // wins again when nobody else is requesting.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                          input logic [IW-1:0]      after);
    logic          found;
    logic [IW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(after) + k) % NUM_REQ;
      if (!found && valid[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // In BURST last_gnt is the index of the current owner.
  assign busy       = (state == BURST);
  assign cur_valid  = req_valid[last_gnt];
  assign cur_last   = req_last[last_gnt];
  assign accept     = busy & cur_valid & ~fifo_full;
  assign fifo_wr_en = accept;
  assign req_ready  = busy ? (grant & {NUM_REQ{~fifo_full}}) : '0;
  assign fifo_din   = busy ? req_data[{last_gnt, 3'b000} +: DATA_W] : '0;

  assign hit_last    = accept & cur_last;
  assign hit_max     = accept & (({1'b0, beat_cnt} + 9'd1) >= 9'(MAX_BURST));
  assign hit_stall   = busy & ~cur_valid & (({1'b0, stall_cnt} + 9'd1) >= 9'(STALL_LIMIT));
  assign burst_abort = hit_stall;
  assign end_burst   = hit_last | hit_max | hit_stall;

  assign {win_found, win_idx} = rr_pick(req_valid, last_gnt);

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    last_gnt_n  = last_gnt;
    beat_cnt_n  = beat_cnt;
    stall_cnt_n = stall_cnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n     = BURST;
          grant_n     = NUM_REQ'(1) << win_idx;
          last_gnt_n  = win_idx;
          beat_cnt_n  = '0;
          stall_cnt_n = '0;
        end
      end
      BURST: begin
        // Backpressure with valid high leaves stall_cnt untouched.
        if (accept) begin
          beat_cnt_n  = sat_inc(beat_cnt);
          stall_cnt_n = '0;
        end else if (!cur_valid) begin
          stall_cnt_n = sat_inc(stall_cnt);
        end
        if (end_burst) begin
          beat_cnt_n  = '0;
          stall_cnt_n = '0;
          if (win_found) begin
            grant_n    = NUM_REQ'(1) << win_idx;
            last_gnt_n = win_idx;
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      last_gnt  <= IW'(NUM_REQ - 1);
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      last_gnt  <= last_gnt_n;
      beat_cnt  <= beat_cnt_n;
      stall_cnt <= stall_cnt_n;
    end
  end

endmodule
